fan_packet_tx: RTL
==================

Name: fan_packet_tx

Overview:
- Parametrised successor to the fixed-format fan-remote packet generator.
- Serialises a preamble, an ID field and a payload field into a three-phase pulse-width symbol stream: low, data, high.
- Adds configurable field widths, symbol timing and inter-packet gap, plus an N-times repeat with a start/busy/done handshake and abort.
- Sits between the command decoder and the RF/OOK transmitter pin driver.

Parameters:
- SUB_PERIOD, 2203: ref_clk cycles per sub-phase. Symbol = 3*SUB_PERIOD cycles.
- ID_WIDTH, 4: remote ID field width in bits.
- PAYLOAD_WIDTH, 7: command payload width in bits.
- PREAMBLE_SYMS, 2: leading data-0 symbols per packet.
- GAP_SYMS, 8: symbol times of constant low after each packet.
- RPT_WIDTH, 4: width of the repeat-count input.

Ports:
- ref_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a transmission. Sampled only in IDLE.
- abort  in  1  cancel any transmission immediately.
- cmd_id  in  ID_WIDTH  ID, captured at start.
- cmd_payload  in  PAYLOAD_WIDTH  payload, captured at start.
- repeats  in  RPT_WIDTH  packet count, captured at start. 0 is treated as 1.
- busy  out  1  high from the cycle after start acceptance until completion.
- done  out  1  one-cycle pulse on normal completion.
- out  out  1  registered serial symbol output.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, out=0, busy=0, done=0, all counters 0.
- States:
  - IDLE: out=0. If start && !abort, capture cmd_id, cmd_payload, max(repeats,1) and go to SEND. Next cycle: busy=1, symbol 0 phase 0 begins.
  - SEND: symbols 0..N-1, where N = PREAMBLE_SYMS+ID_WIDTH+PAYLOAD_WIDTH (+1 with the parity feature).
  - GAP: out=0 for GAP_SYMS*3*SUB_PERIOD cycles.
- Symbol k = phase 0 (out=0), phase 1 (out=bit k), phase 2 (out=1). Each phase lasts exactly SUB_PERIOD cycles.
- Bit k by position:
  - k < PREAMBLE_SYMS: 0.
  - Next ID_WIDTH symbols: cmd_id, LSB first.
  - Next PAYLOAD_WIDTH symbols: cmd_payload, LSB first.
- After the last phase-2 of symbol N-1: go to GAP.
- At the end of GAP: decrement the remaining count. If nonzero, go to SEND (symbol 0). If zero, go to IDLE; busy drops and done=1 on that same edge, for one cycle.
- Total busy duration = R*(N+GAP_SYMS)*3*SUB_PERIOD cycles.
- The sub-phase prescaler counts SUB_PERIOD-1 down to 0. Width = clog2(SUB_PERIOD), minimum 1. SUB_PERIOD=1 is legal: phases change every cycle.
- start while busy: ignored. Captured fields do not change mid-transmission.
- abort (any state): next edge goes to IDLE with out=0, busy=0, done=0.
- start and abort together in IDLE: abort wins, nothing starts.
- Inputs other than start/abort are don't-care outside the capture cycle.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FAN_PACKET_TX_PARITY_EN.
- Defined: one extra symbol after the payload carrying even parity over cmd_id and cmd_payload (XOR of all captured bits). N grows by 1.
- Undefined: no parity symbol. The packet ends after the payload MSB.

Decomposition:
- Package fan_pkt_pkg holds:
  - state enum {IDLE, SEND, GAP};
  - phase encoding {PH_LOW=0, PH_DATA=1, PH_HIGH=2};
  - default timing constants (SUB_PERIOD_DEFAULT=2203, GAP_SYMS_DEFAULT).
- One sub-module, fan_symbol_timer: a SUB_PERIOD prescaler plus a 0..2 phase counter.
  - Inputs: clear, enable.
  - Outputs: phase, phase_end, sym_end.
  - fan_packet_tx owns the FSM, bit index, shift/select and repeat counter.

Test Plan:
- SUB_PERIOD=1, defaults otherwise, cmd_id=4'b1010, cmd_payload=7'b1001111, repeats=1 -> out from cycle after start:
  - preamble: 001 001;
  - ID: 001 011 001 011;
  - payload: 011 011 011 011 001 001 011;
  - then 24 cycles low. done pulses once, busy high for exactly 63 cycles.
- SUB_PERIOD=3, repeats=3 -> each out level holds exactly 3 cycles. Three identical packets, each followed by a GAP_SYMS*9-cycle low gap. busy = 3*(13+8)*9 = 567 cycles.
- repeats=0 -> behaves exactly as repeats=1 (one packet, one done).
- Re-assert start and change cmd_id mid-packet -> waveform unchanged, no restart, single done.
- abort in the middle of the ID field -> next cycle out=0, busy=0, no done pulse. A new start then produces a full packet from preamble.
- reset_n pulsed low asynchronously mid-GAP -> out/busy/done go 0 without a clock edge. After release, IDLE with no output activity until start.
- Parity build, id=4'b1010, payload=7'b1001111 -> XOR = 1, so symbol 13 = 011. busy extends by 3*SUB_PERIOD.

Source files
------------

// File: rtl/fan_pkt_pkg.sv
// Shared types and timing defaults for the fan-remote packet transmitter.
// FAN_PACKET_TX_PARITY_EN appends one even-parity symbol after the payload.
package fan_pkt_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  typedef enum logic [1:0] {
    PH_LOW  = 2'd0,
    PH_DATA = 2'd1,
    PH_HIGH = 2'd2
  } phase_e;

  localparam int SUB_PERIOD_DEFAULT = 2203;
  localparam int GAP_SYMS_DEFAULT   = 8;

`ifdef FAN_PACKET_TX_PARITY_EN
  localparam int PARITY_SYMS = 1;
`else
  localparam int PARITY_SYMS = 0;
`endif

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fan_symbol_timer.sv
// Sub-phase prescaler plus low/data/high phase counter; one symbol is
// three phases of SUB_PERIOD cycles each.
module fan_symbol_timer
  import fan_pkt_pkg::*;
#(
  parameter int SUB_PERIOD = SUB_PERIOD_DEFAULT
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_clear,
  input  logic   i_enable,
  output phase_e o_phase,
  output logic   o_phase_end,
  output logic   o_sym_end
);

  localparam int               PRE_W   = clog2_min1(SUB_PERIOD);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SUB_PERIOD - 1);

  logic [PRE_W-1:0] r_pre;
  phase_e           r_phase;
  phase_e           w_phase_nxt;

  assign o_phase     = r_phase;
  assign o_phase_end = i_enable && (r_pre == '0);
  assign o_sym_end   = o_phase_end && (r_phase == PH_HIGH);

  always_comb begin
    w_phase_nxt = PH_LOW;
    case (r_phase)
      PH_LOW:  w_phase_nxt = PH_DATA;
      PH_DATA: w_phase_nxt = PH_HIGH;
      default: w_phase_nxt = PH_LOW;
    endcase
  end

  // Clear reloads a full sub-phase so the first phase after start is not short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_phase <= PH_LOW;
    end else if (i_clear) begin
      r_pre   <= PRE_MAX;
      r_phase <= PH_LOW;
    end else if (i_enable) begin
      if (r_pre == '0) begin
        r_pre   <= PRE_MAX;
        r_phase <= w_phase_nxt;
      end else begin
        r_pre <= r_pre - 1'b1;
      end
    end
  end

endmodule

// File: rtl/fan_packet_tx.sv
// Fan-remote packet transmitter: preamble, ID and payload as low/data/high
// pulse-width symbols, N-times repeat with gap. Option: FAN_PACKET_TX_PARITY_EN.
module fan_packet_tx
  import fan_pkt_pkg::*;
#(
  parameter int SUB_PERIOD    = SUB_PERIOD_DEFAULT,
  parameter int ID_WIDTH      = 4,
  parameter int PAYLOAD_WIDTH = 7,
  parameter int PREAMBLE_SYMS = 2,
  parameter int GAP_SYMS      = GAP_SYMS_DEFAULT,
  parameter int RPT_WIDTH     = 4
) (
  input  logic                     i_ref_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [ID_WIDTH-1:0]      i_cmd_id,
  input  logic [PAYLOAD_WIDTH-1:0] i_cmd_payload,
  input  logic [RPT_WIDTH-1:0]     i_repeats,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_out
);

  localparam int N     = PREAMBLE_SYMS + ID_WIDTH + PAYLOAD_WIDTH + PARITY_SYMS;
  localparam int IDX_W = clog2_min1((N > GAP_SYMS) ? N : GAP_SYMS);
  localparam logic [IDX_W-1:0] LAST_SYM = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_GAP = IDX_W'(GAP_SYMS - 1);

  state_e               r_state, w_state;
  logic [N-1:0]         r_pkt, w_pkt, w_pkt_cap, w_sh;
  logic [RPT_WIDTH-1:0] r_rpt, w_rpt;
  logic [IDX_W-1:0]     r_idx, w_idx;
  logic                 r_out, w_out;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 w_accept;
  phase_e               w_phase;
  logic                 w_phase_end, w_sym_end;

  fan_symbol_timer #(.SUB_PERIOD(SUB_PERIOD)) u_tmr (
    .i_clk       (i_ref_clk),
    .i_rst_n     (i_reset_n),
    .i_clear     (w_accept | i_abort),
    .i_enable    (r_state != IDLE),
    .o_phase     (w_phase),
    .o_phase_end (w_phase_end),
    .o_sym_end   (w_sym_end)
  );

  // Whole packet as a bit-per-symbol vector, symbol 0 at bit 0.
  always_comb begin
    w_pkt_cap = '0;
    w_pkt_cap[PREAMBLE_SYMS +: ID_WIDTH] = i_cmd_id;
    w_pkt_cap[PREAMBLE_SYMS+ID_WIDTH +: PAYLOAD_WIDTH] = i_cmd_payload;
`ifdef FAN_PACKET_TX_PARITY_EN
    w_pkt_cap[N-1] = ^{i_cmd_payload, i_cmd_id};
`endif
  end

  assign w_sh = r_pkt >> r_idx;

  // r_idx is the symbol index in SEND and the gap-symbol index in GAP.
  always_comb begin
    w_state  = r_state;
    w_pkt    = r_pkt;
    w_rpt    = r_rpt;
    w_idx    = r_idx;
    w_out    = r_out;
    w_busy   = r_busy;
    w_done   = 1'b0;
    w_accept = 1'b0;
    if (i_abort) begin
      w_state = IDLE;
      w_idx   = '0;
      w_out   = 1'b0;
      w_busy  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_out = 1'b0;
          if (i_start) begin
            w_accept = 1'b1;
            w_state  = SEND;
            w_pkt    = w_pkt_cap;
            w_rpt    = (i_repeats == '0) ? RPT_WIDTH'(1) : i_repeats;
            w_idx    = '0;
            w_busy   = 1'b1;
          end
        end
        SEND: begin
          if (w_phase_end) begin
            case (w_phase)
              PH_LOW:  w_out = w_sh[0];
              PH_DATA: w_out = 1'b1;
              default: w_out = 1'b0;
            endcase
            if (w_sym_end) begin
              if (r_idx == LAST_SYM) begin
                w_state = GAP;
                w_idx   = '0;
              end else begin
                w_idx = r_idx + 1'b1;
              end
            end
          end
        end
        GAP: begin
          w_out = 1'b0;
          if (w_sym_end) begin
            if (r_idx == LAST_GAP) begin
              w_idx = '0;
              w_rpt = r_rpt - 1'b1;
              if (r_rpt == RPT_WIDTH'(1)) begin
                w_state = IDLE;
                w_busy  = 1'b0;
                w_done  = 1'b1;
              end else begin
                w_state = SEND;
              end
            end else begin
              w_idx = r_idx + 1'b1;
            end
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_pkt   <= '0;
      r_rpt   <= '0;
      r_idx   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pkt   <= w_pkt;
      r_rpt   <= w_rpt;
      r_idx   <= w_idx;
      r_out   <= w_out;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign o_out  = r_out;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
